// File: rtl/spi_master_sched.sv
// Two-requester SPI mode-0 master. A round-robin arbiter picks one requester
// in IDLE; the FSM then runs chip-select setup, 8*N sclk periods, hold and a
// gap before the next grant can be taken. All SPI pins and client outputs are
// driven straight from flops.
module spi_master_sched #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [2:0]  len0,
  input  logic [2:0]  len1,
  input  logic [63:0] txd0,
  input  logic [63:0] txd1,
  output logic [1:0]  ack,
  output logic [63:0] rxd,
  output logic        busy,
  output logic        cs_b,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso
);

  // Half-period counter wide enough to hold CLK_DIV-1.
  localparam int CW = $clog2(CLK_DIV) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_HIGH  = 3'd2;
  localparam logic [2:0] S_LOW   = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;

  // Index of the final bit of an N-byte transfer: 8*N-1, where a length
  // code of 0 means eight bytes (len-1 wraps to 7 in three bits).
  function automatic logic [5:0] last_bit_idx(input logic [2:0] len);
    logic [2:0] nm1;
    nm1 = len - 3'd1;
    return {nm1, 3'b111};
  endfunction

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0]    bit_q, bit_d;
  logic [2:0]    len_q, len_d;
  logic          grant_q, grant_d;
  logic          last_q, last_d;
  logic [62:0]   tx_q, tx_d;      // bits still to send after the current one
  logic [63:0]   rx_q, rx_d;
  logic [63:0]   rxd_q, rxd_d;
  logic [1:0]    ack_q, ack_d;
  logic          busy_q, busy_d;
  logic          cs_b_q, cs_b_d;
  logic          sclk_q, sclk_d;
  logic          mosi_q, mosi_d;

  logic          grant_s;
  logic [2:0]    sel_len_s;
  logic [63:0]   sel_txd_s;
  logic          cnt_done_s;
  logic          last_bit_s;

  assign ack  = ack_q;
  assign rxd  = rxd_q;
  assign busy = busy_q;
  assign cs_b = cs_b_q;
  assign sclk = sclk_q;
  assign mosi = mosi_q;

  assign cnt_done_s = (cnt_q == CNT_LAST);
  assign last_bit_s = (bit_q == last_bit_idx(len_q));

  // Round-robin choice: favour the requester not served last time.
  always_comb begin
    grant_s = 1'b0;
    if (req[~last_q]) begin
      grant_s = ~last_q;
    end else begin
      grant_s = last_q;
    end
  end

  // Mux the winning requester's length and payload.
  always_comb begin
    sel_len_s = len0;
    sel_txd_s = txd0;
    if (grant_s) begin
      sel_len_s = len1;
      sel_txd_s = txd1;
    end else begin
      sel_len_s = len0;
      sel_txd_s = txd0;
    end
  end

  // Transaction sequencer: next state, counters, shift registers and pins.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    len_d   = len_q;
    grant_d = grant_q;
    last_d  = last_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rxd_d   = rxd_q;
    ack_d   = 2'b00;
    busy_d  = busy_q;
    cs_b_d  = cs_b_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (req != 2'b00) begin
          grant_d = grant_s;
          last_d  = grant_s;
          len_d   = sel_len_s;
          tx_d    = sel_txd_s[62:0];
          mosi_d  = sel_txd_s[63];
          rx_d    = 64'd0;
          bit_d   = 6'd0;
          cs_b_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = S_SETUP;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_SETUP: begin
        if (cnt_done_s) begin
          cnt_d   = '0;
          sclk_d  = 1'b1;
          rx_d    = {rx_q[62:0], miso};
          state_d = S_HIGH;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_HIGH: begin
        if (cnt_done_s) begin
          cnt_d  = '0;
          sclk_d = 1'b0;
          if (last_bit_s) begin
            // Final bit: leave mosi where it is through the hold period.
            state_d = S_HOLD;
          end else begin
            bit_d   = bit_q + 6'd1;
            mosi_d  = tx_q[62];
            tx_d    = {tx_q[61:0], 1'b0};
            state_d = S_LOW;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_LOW: begin
        if (cnt_done_s) begin
          cnt_d   = '0;
          sclk_d  = 1'b1;
          rx_d    = {rx_q[62:0], miso};
          state_d = S_HIGH;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_HOLD: begin
        if (cnt_done_s) begin
          cnt_d  = '0;
          cs_b_d = 1'b1;
          mosi_d = 1'b0;
          rxd_d  = rx_q;
          if (grant_q) begin
            ack_d = 2'b10;
          end else begin
            ack_d = 2'b01;
          end
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_GAP: begin
        if (cnt_done_s) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        cnt_d   = '0;
        busy_d  = 1'b0;
        cs_b_d  = 1'b1;
        sclk_d  = 1'b0;
        mosi_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset; cs_b rises at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= 6'd0;
      len_q   <= 3'd0;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      tx_q    <= 63'd0;
      rx_q    <= 64'd0;
      rxd_q   <= 64'd0;
      ack_q   <= 2'b00;
      busy_q  <= 1'b0;
      cs_b_q  <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      len_q   <= len_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rxd_q   <= rxd_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      cs_b_q  <= cs_b_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
    end
  end

endmodule

// File: doc/spi_master_sched.md
# spi_master_sched

Two-requester SPI master controller. It arbitrates round-robin between two transaction requesters and sequences one SPI mode-0 transaction (cs_b, sclk, mosi, miso) of 1–8 bytes for the winner. It returns the received bytes with a completion pulse. It sits between on-chip clients and an external SPI slave that samples mosi on sclk rise and updates miso on sclk fall.

## Interface
- CLK_DIV, 4: system clocks per sclk half-period; also the cs_b setup, hold and gap length; ≥1.
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req  in  2  req[i] requests a transaction for requester i; level, held until ack[i].
- len0  in  3  requester 0 byte count; 1–7 = that count, 0 = 8.
- len1  in  3  requester 1 byte count, same encoding.
- txd0  in  64  requester 0 tx bytes; byte k = txd0[63-8k -: 8], sent first byte first, MSB first.
- txd1  in  64  requester 1 tx bytes, same layout.
- ack  out  2  one-cycle completion pulse for the served requester.
- rxd  out  64  received bytes, right-aligned; last received byte in rxd[7:0]; unused upper bits zero.
- busy  out  1  high from the accept cycle through the end of GAP.
- cs_b  out  1  chip select, active low.
- sclk  out  1  SPI clock, idle low.
- mosi  out  1  master out.
- miso  in  1  master in; may be z/x while cs_b=1; never sampled then.

## Operation
- Reset values: cs_b=1, sclk=0, mosi=0, ack=0, busy=0, rxd=0. Round-robin pointer last=1, so requester 0 wins the first tie.
- FSM states: IDLE, SETUP, HIGH, LOW, HOLD, GAP.
- **IDLE.** If any req is set, grant req[~last] if asserted, else the other requester. On that edge:
  - latch txd, len and the grant index; set last to the granted index;
  - set cs_b=0, mosi = latched txd bit 63, busy=1;
  - clear the shift-in register; go to SETUP.
- **SETUP.** CLK_DIV cycles, sclk=0, then go to HIGH.
- **HIGH.** On the entry edge, sclk←1 and miso is shifted into the rx register LSB. Hold CLK_DIV cycles, then:
  - if the bit is not the last (8·N bits total): go to LOW; on that edge sclk←0 and mosi←next tx bit;
  - if the bit is the last: go to HOLD; sclk←0 and mosi is unchanged.
- **LOW.** CLK_DIV cycles, then go to HIGH.
- **HOLD.** CLK_DIV cycles. On exit:
  - cs_b←1, mosi←0;
  - ack[grant]←1 for exactly one cycle;
  - rxd←rx register, zero-extended;
  - go to GAP.
- **GAP.** CLK_DIV cycles with cs_b=1, so the slave sees a clean cs_b rise. Then busy←0 and go to IDLE.
- The next grant is taken in IDLE no earlier than the cycle after busy falls.
- req deassertion mid-transaction is ignored; the transaction completes and acks anyway.
- txd and len changes after accept are ignored.
- rxd holds its value until the next ack; it is not cleared when ack falls.
- A requester holding req continuously alternates with the other requester when both request; it never gets back-to-back service while the other is waiting.
- rst asserted in any state: on that edge all outputs return to reset values, with no ack and no further sclk edge. cs_b rises immediately, and the pointer is reset.

## Timing
- Accept edge to first sclk rise: CLK_DIV cycles.
- sclk period: 2·CLK_DIV cycles; 8·N rising edges per transaction.
- cs_b low duration: CLK_DIV·(1+16·N) cycles.
- ack rises on the same edge as cs_b rises. busy falls CLK_DIV cycles later.
- Minimum spacing between consecutive accepts: CLK_DIV·(2+16·N)+1 cycles.
- mosi changes only on sclk falling edges (or at the cs_b fall). miso is sampled only on sclk rising edges.
- Counters: a half-period counter of width clog2(CLK_DIV)+1 and a 6-bit bit counter (up to 64).

## Test plan
- **Loopback, single byte.** CLK_DIV=2, miso tied to mosi, req=01, len0=1, txd0=64'hA5xx…. Expect:
  - cs_b low for 34 cycles;
  - 8 sclk rises; mosi sequence 1,0,1,0,0,1,0,1;
  - ack=01 for one cycle; rxd=64'h00000000000000A5.
- **Full 8-byte.** len1=0, txd1=64'h0123456789ABCDEF, loopback. Expect:
  - 64 sclk rises; rxd=64'h0123456789ABCDEF;
  - ack=10; cs_b low for 2·(1+128)=258 cycles.
- **Tie and fairness.** Both req held from reset. Expect grants in order 0,1,0,1, each ack a one-cycle pulse. busy stays low for ≥1 cycle between the GAP end and the next accept; cs_b stays high for ≥CLK_DIV cycles between transactions.
- **Scripted slave.** Scripted slave drives miso=8'h3C on sclk falls, with its first bit valid at the cs_b fall; len0=1. Expect rxd[7:0]=8'h3C. Also check mosi is stable on every sclk rise.
- **Reset mid-transfer.** Assert rst for one cycle after the 5th sclk rise. Expect on the next edge: cs_b=1, sclk=0, mosi=0, busy=0, ack never pulses, rxd=0. A subsequent req=11 grants requester 0 first.
- **Request withdrawal.** Drop req0 one cycle after accept. Expect the transaction still completes, ack[0] pulses, and no second transaction starts.
